// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with a frame-synchronous double-buffered
// display word, a guard slot per digit, and fully registered pin outputs.
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK_in,
  input  logic                  Reset_in,
  input  logic [4*DIGITS-1:0]   Data_in,
  input  logic [DIGITS-1:0]     Dot_in,
  input  logic [DIGITS-1:0]     Blank_in,
  input  logic                  Load_in,
  output logic [DIGITS-1:0]     Anode_out,
  output logic [6:0]            Segment_out,
  output logic                  Dot_out,
  output logic                  Frame_out
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Pin-level inversion masks; also the inactive (reset) level of each output.
  localparam logic [DIGITS-1:0] ANODE_OFF = ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]        SEG_OFF   = ACTIVE_LOW ? '1 : '0;
  localparam logic              DOT_OFF   = ACTIVE_LOW;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         pend_q, pend_d;
  logic [DIGITS-1:0][3:0]       pend_data_q, pend_data_d;
  logic [DIGITS-1:0]            pend_dot_q, pend_dot_d;
  logic [DIGITS-1:0]            pend_blank_q, pend_blank_d;
  logic [DIGITS-1:0][3:0]       act_data_q, act_data_d;
  logic [DIGITS-1:0]            act_dot_q, act_dot_d;
  logic [DIGITS-1:0]            act_blank_q, act_blank_d;
  logic [DIGITS-1:0]            anode_q, anode_d;
  logic [6:0]                   seg_q, seg_d;
  logic                         dot_q, dot_d;
  logic                         frame_q, frame_d;

  logic cnt_wrap;
  logic boundary;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    cnt_wrap     = (cnt_q == CNT_LAST);
    boundary     = cnt_wrap && (idx_q == IDX_LAST);

    cnt_d        = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (cnt_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    pend_dot_d   = pend_dot_q;
    pend_blank_d = pend_blank_q;
    act_data_d   = act_data_q;
    act_dot_d    = act_dot_q;
    act_blank_d  = act_blank_q;

    // A load landing on the boundary bypasses the pending bank entirely.
    if (boundary) begin
      pend_d = 1'b0;
      if (Load_in) begin
        act_data_d  = Data_in;
        act_dot_d   = Dot_in;
        act_blank_d = Blank_in;
      end else if (pend_q) begin
        act_data_d  = pend_data_q;
        act_dot_d   = pend_dot_q;
        act_blank_d = pend_blank_q;
      end
    end else if (Load_in) begin
      pend_d       = 1'b1;
      pend_data_d  = Data_in;
      pend_dot_d   = Dot_in;
      pend_blank_d = Blank_in;
    end

    // Guard slot (cnt==0) keeps everything dark to suppress ghosting.
    anode_d = ANODE_OFF;
    seg_d   = SEG_OFF;
    dot_d   = DOT_OFF;
    if (cnt_q != '0) begin
      anode_d = ANODE_OFF ^ (DIGITS'(1) << idx_q);
      if (!act_blank_q[idx_q]) begin
        seg_d = SEG_OFF ^ hex_decode(act_data_q[idx_q]);
        dot_d = DOT_OFF ^ act_dot_q[idx_q];
      end
    end

    frame_d = boundary;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLK_in) begin
    if (Reset_in) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_dot_q   <= '0;
      pend_blank_q <= '1;
      act_data_q   <= '0;
      act_dot_q    <= '0;
      act_blank_q  <= '1;
      anode_q      <= ANODE_OFF;
      seg_q        <= SEG_OFF;
      dot_q        <= DOT_OFF;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_data_q  <= pend_data_d;
      pend_dot_q   <= pend_dot_d;
      pend_blank_q <= pend_blank_d;
      act_data_q   <= act_data_d;
      act_dot_q    <= act_dot_d;
      act_blank_q  <= act_blank_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dot_q        <= dot_d;
      frame_q      <= frame_d;
    end
  end

  assign Anode_out   = anode_q;
  assign Segment_out = seg_q;
  assign Dot_out     = dot_q;
  assign Frame_out   = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random loads/resets,
// all checked cycle by cycle against a time-indexed reference model.
module tb_seg7_scan_driver;
  localparam int D     = 4;
  localparam int SD    = 4;
  localparam int FRAME = D * SD;

  logic        clk = 1'b0;
  logic        Reset_in = 1'b1;
  logic [15:0] Data_in  = '0;
  logic [3:0]  Dot_in   = '0;
  logic [3:0]  Blank_in = '0;
  logic        Load_in  = 1'b0;
  logic [3:0]  Anode_out;
  logic [6:0]  Segment_out;
  logic        Dot_out;
  logic        Frame_out;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut (
    .CLK_in(clk), .Reset_in(Reset_in), .Data_in(Data_in), .Dot_in(Dot_in),
    .Blank_in(Blank_in), .Load_in(Load_in), .Anode_out(Anode_out),
    .Segment_out(Segment_out), .Dot_out(Dot_out), .Frame_out(Frame_out)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  // Hex glyphs written g..a, straight from the display table.
  logic [6:0] glyph [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                             7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  // Reference model: position in the scan is derived from cycles since reset.
  int          t = 0;
  bit          m_pend;
  logic [15:0] p_data, a_data;
  logic [3:0]  p_dot, p_blank, a_dot, a_blank;
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_dot, e_frame;

  task automatic model_step(input bit rst, input bit ld, input logic [15:0] data,
                            input logic [3:0] dot, input logic [3:0] blank);
    int cnt, idx;
    bit bnd;
    logic [3:0] an;
    logic [6:0] sg;
    logic dp;
    if (rst) begin
      t = 0; m_pend = 0;
      p_data = '0; p_dot = '0; p_blank = '1;
      a_data = '0; a_dot = '0; a_blank = '1;
      e_anode = '1; e_seg = '1; e_dot = 1'b1; e_frame = 1'b0;
    end else begin
      cnt = t % SD;
      idx = (t / SD) % D;
      bnd = (t % FRAME) == FRAME - 1;
      an = '0; sg = '0; dp = 1'b0;
      if (cnt != 0) begin
        an[idx] = 1'b1;
        if (!a_blank[idx]) begin
          sg = glyph[a_data[idx*4 +: 4]];
          dp = a_dot[idx];
        end
      end
      e_anode = ~an; e_seg = ~sg; e_dot = ~dp; e_frame = bnd;
      if (bnd) begin
        if (ld) begin
          a_data = data; a_dot = dot; a_blank = blank;
        end else if (m_pend) begin
          a_data = p_data; a_dot = p_dot; a_blank = p_blank;
        end
        m_pend = 0;
      end else if (ld) begin
        p_data = data; p_dot = dot; p_blank = blank; m_pend = 1;
      end
      t++;
    end
  endtask

  task automatic cycle(input bit rst, input bit ld, input logic [15:0] data,
                       input logic [3:0] dot, input logic [3:0] blank);
    Reset_in = rst; Load_in = ld; Data_in = data; Dot_in = dot; Blank_in = blank;
    @(posedge clk);
    model_step(rst, ld, data, dot, blank);
    #1;
    check("anode", Anode_out, e_anode);
    check("segment", Segment_out, e_seg);
    check("dot", Dot_out, e_dot);
    check("frame", Frame_out, e_frame);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 16'h0, 4'h0, 4'h0);
  endtask

  // Advance until the next edge processes scan position `phase` of the frame.
  task automatic idle_until(input int phase);
    for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) cycle(0, 0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    // Reset then idle: display dark, frame pulse every 16 cycles.
    cycle(1, 0, 16'h0, 4'h0, 4'h0);
    cycle(1, 0, 16'h0, 4'h0, 4'h0);
    check("rst_anode", Anode_out, 4'hF);
    check("rst_seg", Segment_out, 7'h7F);
    idle(40);

    // Mid-frame load of 1A3F with dot on digit 1.
    idle_until(6);
    cycle(0, 1, 16'h1A3F, 4'b0010, 4'b0000);
    idle(36);

    // Two loads before the boundary: only the last is displayed.
    idle_until(3);
    cycle(0, 1, 16'h0000, 4'h0, 4'h0);
    cycle(0, 1, 16'h8888, 4'h0, 4'h0);
    idle(36);

    // Load exactly on the boundary: visible on digit 0 two edges later.
    idle_until(FRAME - 1);
    cycle(0, 1, 16'hBEEF, 4'h0, 4'h0);
    idle(1);
    check("beef_guard_anode", Anode_out, 4'hF);
    idle(1);
    check("beef_d0_anode", Anode_out, 4'b1110);
    check("beef_d0_seg", Segment_out, 7'b0001110);
    idle(20);

    // Reset while digit 2 of 1234 is on the pins.
    idle_until(5);
    cycle(0, 1, 16'h1234, 4'h0, 4'h0);
    idle(16);
    idle_until(10);
    check("pre_rst_d2_anode", Anode_out, 4'b1011);
    cycle(1, 0, 16'h0, 4'h0, 4'h0);
    check("post_rst_anode", Anode_out, 4'hF);
    check("post_rst_seg", Segment_out, 7'h7F);
    idle(40);

    // Blank digit 2 of 5555.
    cycle(0, 1, 16'h5555, 4'h0, 4'b0100);
    idle(20);
    idle_until(10);
    check("blank_d2_anode", Anode_out, 4'b1011);
    check("blank_d2_seg", Segment_out, 7'h7F);
    idle(4);
    check("d3_five_seg", Segment_out, 7'b0010010);
    idle(12);

    // Random loads, held loads and occasional resets.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
            16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
